// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI SRAM burst controller.
// Holds the FSM state encoding, SPI opcodes and the parameter legality check.
package spi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    GUARD  = 2'd3
  } state_e;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;

  function automatic bit params_legal(input int addr_w, input int data_w, input int clk_div);
    bit aw_ok;
    bit dw_ok;
    aw_ok = (addr_w == 16) || (addr_w == 24);
    dw_ok = (data_w == 8) || (data_w == 16) || (data_w == 24) || (data_w == 32);
    return aw_ok && dw_ok && (clk_div >= 1);
  endfunction

endpackage

// File: rtl/spi_sclk_timer.sv
// SCLK half-period timer: counts CLK_DIV cycles per half-period and emits
// per-bit phase strobes. Held cleared whenever en is low.
module spi_sclk_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk_phase,
  output logic bit_start,
  output logic sample,
  output logic bit_end,
  output logic half_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // phase 0 is the sclk-low half of a bit, phase 1 the sclk-high half
  assign sclk_phase = phase;
  assign half_end   = en && (cnt == LAST);
  assign bit_start  = en && !phase && (cnt == '0);
  assign sample     = en &&  phase && (cnt == '0);
  assign bit_end    = en &&  phase && (cnt == LAST);

endmodule

// File: rtl/spi_sram_burst_ctrl.sv
// CPU-word to SPI SRAM bridge: one frame per request (opcode, address, data
// bytes little-endian), mode 0, with a chip-select guard gap between frames.
module spi_sram_burst_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int NBITS    = 8 + ADDR_W + DATA_W;
  localparam int CNT_W    = $clog2(NBITS + 1);
  localparam int HDR_BITS = 8 + ADDR_W;
  localparam int NBYTES   = DATA_W / 8;

  generate
    if (!params_legal(ADDR_W, DATA_W, CLK_DIV)) begin : g_bad_params
      $error("spi_sram_burst_ctrl: illegal ADDR_W/DATA_W/CLK_DIV combination");
    end
  endgenerate

  // Byte k of the word goes on the wire k-th; the mapping is its own inverse.
  function automatic logic [DATA_W-1:0] wire_order(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NBYTES; k++) r[DATA_W-1-8*k -: 8] = d[8*k +: 8];
    return r;
  endfunction

  state_e             state, state_nxt;
  logic [NBITS-1:0]   shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               req_we;
  logic [DATA_W-1:0]  rd_sh;

  logic sclk_phase, bit_start, sample, bit_end, half_end;
  logic in_shift, accept, timer_en, last_bit, data_bit, take_miso;
  logic [DATA_W-1:0] rd_next, rd_fill;
  logic [NBITS-1:0]  frame;

  assign in_shift  = (state == SHIFT);
  assign accept    = (state == IDLE) && mem_req;
  assign timer_en  = in_shift || (state == GUARD);
  assign last_bit  = in_shift && bit_end && (bit_cnt == CNT_W'(NBITS));
  // bit_cnt is the 1-based index of the bit on the wire
  assign data_bit  = bit_cnt > CNT_W'(HDR_BITS);
  assign take_miso = in_shift && sample && data_bit;
  assign rd_next   = {rd_sh[DATA_W-2:0], spi_miso};
  assign rd_fill   = take_miso ? rd_next : rd_sh;
  assign frame     = {(mem_we ? SPI_OP_WRITE : SPI_OP_READ), mem_addr,
                      (mem_we ? wire_order(mem_wdata) : {DATA_W{1'b0}})};

  spi_sclk_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (timer_en),
    .sclk_phase (sclk_phase),
    .bit_start  (bit_start),
    .sample     (sample),
    .bit_end    (bit_end),
    .half_end   (half_end)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_req)  state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FINISH;
      FINISH:                state_nxt = GUARD;
      GUARD:   if (half_end) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b0;
    spi_mosi  = 1'b0;
    mem_ready = 1'b0;
    case (state)
      SHIFT: begin
        spi_cs_n = 1'b0;
        spi_sclk = sclk_phase;
        spi_mosi = shreg[NBITS-1];
      end
      FINISH:  mem_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      req_we    <= 1'b0;
      rd_sh     <= '0;
      mem_rdata <= '0;
    end else if (accept) begin
      shreg   <= frame;
      bit_cnt <= '0;
      req_we  <= mem_we;
    end else if (in_shift) begin
      if (bit_start) bit_cnt <= bit_cnt + CNT_W'(1);
      // shifting at the end of a bit keeps MOSI stable for the whole next bit
      if (bit_end)   shreg   <= {shreg[NBITS-2:0], 1'b0};
      if (take_miso) rd_sh   <= rd_next;
      if (last_bit && !req_we) mem_rdata <= wire_order(rd_fill);
    end
  end

endmodule

// File: tb/tb_spi_sram_burst_ctrl.sv
// Bench for spi_sram_burst_ctrl: two instances (default and 24/32/3) driven by
// directed transactions against a behavioural SPI SRAM slave and timing model.
module tb_spi_sram_burst_ctrl;

  localparam int AW0 = 16, DW0 = 16, D0 = 1;
  localparam int AW1 = 24, DW1 = 32, D1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst = 1'b1, a_req = 1'b0, a_we = 1'b0, a_miso = 1'b0;
  logic a_cs, a_sck, a_mosi, a_rdy;
  logic [AW0-1:0] a_addr = '0;
  logic [DW0-1:0] a_wd = '0, a_rd;

  logic b_rst = 1'b1, b_req = 1'b0, b_we = 1'b0, b_miso = 1'b0;
  logic b_cs, b_sck, b_mosi, b_rdy;
  logic [AW1-1:0] b_addr = '0;
  logic [DW1-1:0] b_wd = '0, b_rd;

  spi_sram_burst_ctrl #(.ADDR_W(AW0), .DATA_W(DW0), .CLK_DIV(D0)) dut_a (
    .clk(clk), .reset(a_rst), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wd), .mem_rdata(a_rd), .mem_ready(a_rdy), .spi_cs_n(a_cs),
    .spi_sclk(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  spi_sram_burst_ctrl #(.ADDR_W(AW1), .DATA_W(DW1), .CLK_DIV(D1)) dut_b (
    .clk(clk), .reset(b_rst), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wd), .mem_rdata(b_rd), .mem_ready(b_rdy), .spi_cs_n(b_cs),
    .spi_sclk(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  int nvec = 0, nerr = 0, cyc = 0;
  logic [1:0] rst_q = 2'b11;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= {b_rst, a_rst};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural SPI SRAM + timing model ----------------
  logic [7:0] mem [int];
  int bitn[2], run[2], hi_run[2], gap_last[2], rdy_cnt[2];
  int exp_rdy[2] = '{-1, -1};
  logic [63:0] rx[2], exp_rd[2], pend[2];
  logic [31:0] hdr[2];
  logic [7:0]  op[2];
  logic [23:0] saddr[2];
  logic ps_cs[2] = '{1'b1, 1'b1};
  logic ps_sck[2] = '{1'b0, 1'b0};

  function automatic int aw_of(input int i); return (i == 0) ? AW0 : AW1; endfunction
  function automatic int dw_of(input int i); return (i == 0) ? DW0 : DW1; endfunction
  function automatic int dv_of(input int i); return (i == 0) ? D0 : D1; endfunction

  function automatic int key(input int i, input logic [23:0] a);
    logic [23:0] m;
    m = 24'((32'd1 << aw_of(i)) - 32'd1);
    return i * (1 << 24) + int'(a & m);
  endfunction

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [7:0] rdbyte(input int i, input logic [23:0] a);
    int k;
    k = key(i, a);
    if (mem.exists(k)) return mem[k];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] word_at(input int i, input logic [23:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < dw_of(i) / 8; k++) w[8*k +: 8] = rdbyte(i, 24'(a + 24'(k)));
    return w;
  endfunction

  task automatic set_miso(input int i, input logic v);
    if (i == 0) a_miso = v; else b_miso = v;
  endtask

  task automatic mon(input int i);
    logic cs, sck, mo, rdy;
    logic [63:0] rd;
    logic [7:0] byt;
    int aw, d, n, hb, j;
    aw = aw_of(i); d = dv_of(i); n = 8 + aw + dw_of(i); hb = 8 + aw;
    if (i == 0) begin cs = a_cs; sck = a_sck; mo = a_mosi; rdy = a_rdy; rd = 64'(a_rd); end
    else        begin cs = b_cs; sck = b_sck; mo = b_mosi; rdy = b_rdy; rd = 64'(b_rd); end
    if (rst_q[i]) begin
      chk("reset_cs_n", 64'(cs), 64'd1);
      chk("reset_sclk", 64'(sck), 64'd0);
      chk("reset_mosi", 64'(mo), 64'd0);
      chk("reset_ready", 64'(rdy), 64'd0);
      chk("reset_rdata", rd, 64'd0);
      exp_rdy[i] = -1; exp_rd[i] = '0; bitn[i] = 0; hi_run[i] = 0; op[i] = '0;
      ps_cs[i] = 1'b1; ps_sck[i] = 1'b0;
      set_miso(i, 1'b0);
      return;
    end
    if (cyc == exp_rdy[i] && op[i] == 8'h03) exp_rd[i] = pend[i];
    chk("ready", 64'(rdy), 64'(cyc == exp_rdy[i]));
    if (rdy) rdy_cnt[i]++;
    chk("rdata", rd, exp_rd[i]);
    if (cs) begin
      chk("idle_mosi", 64'(mo), 64'd0);
      chk("idle_sclk", 64'(sck), 64'd0);
      if (!ps_cs[i] && ps_sck[i]) chk("sclk_high_len", 64'(run[i]), 64'(d));
      bitn[i] = 0;
      hi_run[i]++;
      set_miso(i, 1'b0);
    end else if (ps_cs[i]) begin
      exp_rdy[i] = cyc + 2 * d * n;
      gap_last[i] = hi_run[i];
      hi_run[i] = 0; run[i] = 1; op[i] = '0;
    end else if (sck != ps_sck[i]) begin
      chk(sck ? "sclk_low_len" : "sclk_high_len", 64'(run[i]), 64'(d));
      run[i] = 1;
      if (sck) begin
        rx[i] = {rx[i][62:0], mo};
        bitn[i]++;
        if (bitn[i] == hb) begin
          hdr[i]   = 32'(rx[i] & ((64'd1 << hb) - 64'd1));
          op[i]    = 8'(hdr[i] >> aw);
          saddr[i] = 24'(hdr[i] & ((32'd1 << aw) - 32'd1));
          if (op[i] == 8'h03) pend[i] = word_at(i, saddr[i]);
        end else if (bitn[i] > hb && (bitn[i] - hb) % 8 == 0 && op[i] == 8'h02) begin
          mem[key(i, 24'(saddr[i] + 24'((bitn[i] - hb) / 8 - 1)))] = rx[i][7:0];
        end
      end else if (op[i] == 8'h03 && bitn[i] >= hb && bitn[i] < n) begin
        j = bitn[i] - hb;
        byt = rdbyte(i, 24'(saddr[i] + 24'(j / 8)));
        set_miso(i, byt[7 - j % 8]);
      end
    end else begin
      run[i]++;
    end
    ps_cs[i] = cs; ps_sck[i] = sck;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
  end

  // ---------------- driver ----------------
  task automatic drive(input int i, input logic req, input logic we,
                       input logic [23:0] addr, input logic [31:0] wd);
    if (i == 0) begin a_req = req; a_we = we; a_addr = addr[15:0]; a_wd = wd[15:0]; end
    else        begin b_req = req; b_we = we; b_addr = addr;       b_wd = wd;       end
  endtask

  function automatic logic get_rdy(input int i);
    return (i == 0) ? a_rdy : b_rdy;
  endfunction

  task automatic wait_rdy(input int i, output int at);
    at = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (get_rdy(i)) begin at = cyc; break; end
    end
    if (at < 0) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // Request at the current negedge (cycle T); inputs are scrambled at T+1.
  task automatic txn(input int i, input logic we, input logic [23:0] addr,
                     input logic [31:0] wd, output int lat);
    int t0, at;
    drive(i, 1'b1, we, addr, wd);
    t0 = cyc;
    @(negedge clk);
    drive(i, 1'b0, ~we, 24'($urandom), $urandom);
    wait_rdy(i, at);
    lat = (at < 0) ? -1 : at - t0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int lat, t0, r1, r2, rc, at;
    mem[key(0, 24'h001234)] = 8'hCD;
    mem[key(0, 24'h001235)] = 8'hAB;
    repeat (3) @(negedge clk);
    chk("reset_a_cs_n", 64'(a_cs), 64'd1);
    chk("reset_b_rdata", 64'(b_rd), 64'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    // read on the very first idle cycle after reset
    txn(0, 1'b0, 24'h001234, 32'h0, lat);
    chk("a_read_latency", 64'(lat), 64'd81);
    chk("a_read_header", 64'(hdr[0]), 64'h031234);
    chk("a_read_rdata", 64'(a_rd), 64'hABCD);

    txn(0, 1'b1, 24'h00FFFF, 32'h0000BEEF, lat);
    chk("a_write_latency", 64'(lat), 64'd81);
    chk("a_write_frame", rx[0] & ((64'd1 << 40) - 64'd1), 64'h02_FFFF_EFBE);
    chk("a_write_byte0", 64'(rdbyte(0, 24'h00FFFF)), 64'hEF);
    chk("a_write_byte1_wrap", 64'(rdbyte(0, 24'h000000)), 64'hBE);
    chk("a_rdata_after_write", 64'(a_rd), 64'hABCD);

    // reset pulse in the middle of a frame
    rc = rdy_cnt[0];
    drive(0, 1'b1, 1'b0, 24'h000010, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 24'h0, 32'h0);
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bitn[0] == 20) begin at = k; break; end
    end
    if (at < 0) chk("abort_bit20_timeout", 64'd0, 64'd1);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    chk("abort_cs_n", 64'(a_cs), 64'd1);
    repeat (150) @(negedge clk);
    chk("abort_no_ready", 64'(rdy_cnt[0]), 64'(rc));
    txn(0, 1'b0, 24'h000010, 32'h0, lat);
    chk("a_post_abort_latency", 64'(lat), 64'd81);
    chk("a_post_abort_rdata", 64'(a_rd), 64'h4B4A);

    // mem_req held high across two reads
    rc = rdy_cnt[0];
    drive(0, 1'b1, 1'b0, 24'h001234, 32'h0);
    t0 = cyc;
    wait_rdy(0, r1);
    wait_rdy(0, r2);
    drive(0, 1'b0, 1'b0, 24'h0, 32'h0);
    chk("b2b_first_latency", 64'(r1 - t0), 64'd81);
    chk("b2b_second_delta", 64'(r2 - r1), 64'd83);
    chk("b2b_cs_gap", 64'(gap_last[0]), 64'd3);
    chk("b2b_rdata", 64'(a_rd), 64'hABCD);
    repeat (6) @(negedge clk);
    chk("b2b_ready_count", 64'(rdy_cnt[0] - rc), 64'd2);

    // wide instance: 24-bit address, 32-bit data, CLK_DIV=3
    txn(1, 1'b0, 24'h012345, 32'h0, lat);
    chk("b_read_latency", 64'(lat), 64'd385);
    chk("b_read_header", 64'(hdr[1]), 64'h03012345);
    chk("b_read_rdata", 64'(b_rd), 64'h313E3F3C);
    txn(1, 1'b1, 24'hFFFFFE, 32'hDEADBEEF, lat);
    chk("b_write_byte0", 64'(rdbyte(1, 24'hFFFFFE)), 64'hEF);
    chk("b_write_byte2_wrap", 64'(rdbyte(1, 24'h000000)), 64'hAD);
    chk("b_rdata_after_write", 64'(b_rd), 64'h313E3F3C);
    txn(1, 1'b0, 24'hFFFFFE, 32'h0, lat);
    chk("b_readback_rdata", 64'(b_rd), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spi_sram_burst_ctrl.md
SPI_SRAM_BURST_CTRL -- requirements
Module: spi_sram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: SPI address width; legal values 16 or 24.
REQ-002 Parameter DATA_W, default 16: CPU word width; legal values 8, 16, 24 or 32.
REQ-003 Parameter CLK_DIV, default 1: clk cycles per SCLK half-period; must be >=1.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_req  in  1  level request from CPU.
REQ-007 mem_we  in  1  1=write, 0=read; sampled at acceptance.
REQ-008 mem_addr  in  ADDR_W  byte address of the word's low byte.
REQ-009 mem_wdata  in  DATA_W  write data.
REQ-010 mem_rdata  out  DATA_W  read data; holds its value until the next read completes.
REQ-011 mem_ready  out  1  one-cycle completion pulse.
REQ-012 spi_cs_n  out  1  chip select, active low.
REQ-013 spi_sclk  out  1  SPI clock, mode 0 (idles low).
REQ-014 spi_mosi  out  1  serial data out, MSB first.
REQ-015 spi_miso  in  1  serial data in.

Function
REQ-016 The FSM SHALL use the states IDLE, SHIFT, FINISH and GUARD.
REQ-017 In IDLE, mem_req=1 at cycle T SHALL capture mem_we, mem_addr and mem_wdata, and the FSM SHALL enter SHIFT at T+1.
REQ-018 The frame SHALL be opcode (0x03 read / 0x02 write, 8 bits), then mem_addr MSB-first, then DATA_W/8 data bytes, each MSB-first; NBITS = 8+ADDR_W+DATA_W.
REQ-019 Data bytes SHALL be little-endian: byte k on the wire is data[8k+7:8k] and is stored at mem_addr+k; the address wraps per SRAM sequential mode.
REQ-020 In SHIFT, spi_cs_n SHALL be 0; each bit SHALL be CLK_DIV cycles with sclk=0 (MOSI stable from the first of these cycles) followed by CLK_DIV cycles with sclk=1.
REQ-021 spi_miso SHALL be sampled on the clk edge that ends the first sclk=1 cycle of each bit; samples from data bits SHALL be shifted into a read register.
REQ-022 SHIFT SHALL last exactly 2*CLK_DIV*NBITS cycles; FINISH SHALL occur at T+2*CLK_DIV*NBITS+1 with spi_cs_n=1, spi_sclk=0 and mem_ready=1.
REQ-023 On a read, mem_rdata SHALL update in the FINISH cycle; on a write, mem_rdata SHALL be left unchanged.
REQ-024 GUARD SHALL hold spi_cs_n=1 for CLK_DIV cycles and then return to IDLE; mem_req is ignored in FINISH and GUARD.
REQ-025 mem_req still high in IDLE SHALL start a new transaction, giving spi_cs_n=1 for exactly CLK_DIV+2 cycles between frames.
REQ-026 mem_addr, mem_we and mem_wdata changes after acceptance SHALL NOT affect the frame in progress.
REQ-027 spi_mosi SHALL be 0 whenever spi_cs_n=1.
REQ-028 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE with spi_cs_n=1, spi_sclk=0, spi_mosi=0, mem_ready=0 and mem_rdata=0.
REQ-030 Reset asserted mid-SHIFT SHALL abort the frame: spi_cs_n=1 from the next cycle, and no mem_ready pulse is issued for the aborted request.
REQ-031 After reset deasserts, the first IDLE cycle SHALL be able to accept a request.

Structure
REQ-032 Package spi_mem_pkg SHALL hold the state enum, the opcode constants SPI_OP_READ=8'h03 and SPI_OP_WRITE=8'h02, and a parameter-legality check function.
REQ-033 Sub-module spi_sclk_timer SHALL provide the half-period counter and the phase strobes (bit_start, sample, bit_end).
REQ-034 The frame SHALL be shifted out of a single NBITS-wide shift register, with a bit counter of width $clog2(NBITS+1).

Verification
REQ-035 Defaults, read at 0x1234, model holds 0xCD@0x1234 and 0xAB@0x1235 -> MOSI 0x03,0x12,0x34; mem_rdata=0xABCD; one-cycle mem_ready at T+81.
REQ-036 Write 0xBEEF at 0xFFFF -> MOSI 0x02,0xFF,0xFF,0xEF,0xBE; model 0xFFFF=0xEF and 0x0000=0xBE; mem_rdata unchanged.
REQ-037 ADDR_W=24, DATA_W=32, CLK_DIV=3, read at 0x012345 -> sclk low and high for 3 cycles each; mem_ready at T+385; correct 4-byte little-endian word.
REQ-038 Reset pulsed during bit 20 -> spi_cs_n=1 next cycle, no mem_ready; a subsequent read at 0x0010 returns model data correctly.
REQ-039 mem_req held high across two reads -> spi_cs_n high for exactly CLK_DIV+2 cycles between frames; both mem_ready pulses are one cycle wide.
REQ-040 Change mem_addr and mem_wdata to random values at T+1 -> the frame carries the values captured at T.
